// File: rtl/led_status_pkg.sv
// Shared types and helpers for the status-LED sequencer.
package led_status_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PULSE_ON  = 2'd1,
        PULSE_OFF = 2'd2,
        GAP       = 2'd3
    } led_state_e;

    // Width of a counter that runs 0..max_count-1; never narrower than one bit.
    function automatic int cnt_width(input int max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler: one-clock tick every TICK_DIV clocks, restartable via clr.
module led_tick_gen
    import led_status_pkg::*;
#(
    parameter int TICK_DIV = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_status_sequencer.sv
// Shares one status LED between N_REQ requesters: round-robin blink codes,
// heartbeat when idle, and a combinational override for bring-up.
module led_status_sequencer
    import led_status_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int TICK_DIV  = 1000000,
    parameter int ON_TICKS  = 20,
    parameter int OFF_TICKS = 20,
    parameter int GAP_TICKS = 100,
    parameter int HB_TICKS  = 50
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic                       override,
    output logic                       led,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic [N_REQ-1:0]           done
);

    localparam int IDW    = $clog2(N_REQ);
    localparam int PH_MAX = ((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS) > GAP_TICKS
                          ? ((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS) : GAP_TICKS;
    localparam int PW     = cnt_width(PH_MAX);
    localparam int PLW    = cnt_width(N_REQ + 1);
    localparam int HW     = cnt_width(HB_TICKS);

    localparam logic [PW-1:0]  ON_LAST  = PW'(ON_TICKS - 1);
    localparam logic [PW-1:0]  OFF_LAST = PW'(OFF_TICKS - 1);
    localparam logic [PW-1:0]  GAP_LAST = PW'(GAP_TICKS - 1);
    localparam logic [HW-1:0]  HB_LAST  = HW'(HB_TICKS - 1);
    localparam logic [IDW:0]   WRAP     = (IDW + 1)'(N_REQ);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(N_REQ - 1);

    led_state_e       state_q, state_d;
    logic             pattern_q, pattern_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [PLW-1:0]   pulses_q, pulses_d;
    logic [HW-1:0]    hb_cnt_q, hb_cnt_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic [N_REQ-1:0] done_q, done_d;

    logic             tick;
    logic             grant_now;
    logic             req_any;
    logic [IDW-1:0]   win_id;
    logic [IDW:0]     win_sum;
    logic [IDW:0]     win_off;
    logic             found;
    logic [2*N_REQ-1:0] req_rot;

    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (grant_now),
        .tick(tick)
    );

    // Rotate requests so bit 0 is rr_q, then take the first set bit.
    always_comb begin
        req_rot = {req, req} >> rr_q;
        req_any = |req;
        found   = 1'b0;
        win_off = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                win_off = (IDW + 1)'(k);
            end
        end
        win_sum = {1'b0, rr_q} + win_off;
        if (win_sum >= WRAP) begin
            win_sum = win_sum - WRAP;
        end
        win_id = win_sum[IDW-1:0];
    end

    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        phase_d   = phase_q;
        pulses_d  = pulses_q;
        hb_cnt_d  = hb_cnt_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        done_d    = '0;
        grant_now = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_now = 1'b1;
                    grant_d   = win_id;
                    pulses_d  = PLW'(win_id) + PLW'(1);
                    rr_d      = (win_id == ID_LAST) ? '0 : win_id + 1'b1;
                    state_d   = PULSE_ON;
                    pattern_d = 1'b1;
                    phase_d   = '0;
                end else if (tick) begin
                    if (hb_cnt_q == HB_LAST) begin
                        hb_cnt_d  = '0;
                        pattern_d = ~pattern_q;
                    end else begin
                        hb_cnt_d = hb_cnt_q + 1'b1;
                    end
                end
            end

            PULSE_ON: begin
                if (tick) begin
                    if (phase_q == ON_LAST) begin
                        phase_d   = '0;
                        state_d   = PULSE_OFF;
                        pattern_d = 1'b0;
                        pulses_d  = pulses_q - 1'b1;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end

            PULSE_OFF: begin
                if (tick) begin
                    if (phase_q == OFF_LAST) begin
                        phase_d = '0;
                        if (pulses_q != '0) begin
                            state_d   = PULSE_ON;
                            pattern_d = 1'b1;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end

            GAP: begin
                if (tick) begin
                    if (phase_q == GAP_LAST) begin
                        // Heartbeat restarts dark on every return to IDLE.
                        phase_d   = '0;
                        state_d   = IDLE;
                        pattern_d = 1'b0;
                        hb_cnt_d  = '0;
                        for (int k = 0; k < N_REQ; k++) begin
                            if (grant_q == IDW'(k)) begin
                                done_d[k] = 1'b1;
                            end
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= 1'b0;
            phase_q   <= '0;
            pulses_q  <= '0;
            hb_cnt_q  <= '0;
            grant_q   <= '0;
            rr_q      <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            phase_q   <= phase_d;
            pulses_q  <= pulses_d;
            hb_cnt_q  <= hb_cnt_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            done_q    <= done_d;
        end
    end

    assign led      = pattern_q | override;
    assign busy     = (state_q != IDLE);
    assign grant_id = grant_q;
    assign done     = done_q;

endmodule

// File: tb/tb_led_status_sequencer.sv
// Scoreboard bench: a cycle-level reference model predicts LED/busy/done/grant,
// a negedge monitor compares the DUT against the queued predictions.
module tb_led_status_sequencer;

    localparam int NR     = 4;
    localparam int TD     = 4;
    localparam int ON_T   = 2;
    localparam int OFF_T  = 2;
    localparam int GAP_T  = 3;
    localparam int HB_T   = 2;
    localparam int UNIT   = (ON_T + OFF_T) * TD;
    localparam int ON_CLK = ON_T * TD;
    localparam int HB_CLK = HB_T * TD;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] req = '0;
    logic          override = 1'b0;
    logic          led;
    logic          busy;
    logic [1:0]    grant_id;
    logic [NR-1:0] done;

    led_status_sequencer #(
        .N_REQ    (NR),
        .TICK_DIV (TD),
        .ON_TICKS (ON_T),
        .OFF_TICKS(OFF_T),
        .GAP_TICKS(GAP_T),
        .HB_TICKS (HB_T)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .override(override),
        .led     (led),
        .busy    (busy),
        .grant_id(grant_id),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          led;
        logic          busy;
        logic [NR-1:0] done;
        logic [1:0]    gid;
    } exp_t;

    typedef struct {
        int id;
        int cyc;
    } gnt_t;

    exp_t exp_q[$];
    gnt_t grant_q[$];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model state: whole codes are timed by their length in clocks.
    bit m_busy;
    int m_g, m_start, m_end, m_idle, m_rr;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp_v);
        end
    endtask

    function automatic int code_len(input int g);
        return (g + 1) * UNIT + GAP_T * TD;
    endfunction

    function automatic int pick(input logic [NR-1:0] r, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (((r >> ((ptr + k) % NR)) & 4'd1) != 4'd0) begin
                return (ptr + k) % NR;
            end
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_g     = 0;
        m_start = 0;
        m_end   = 0;
        m_idle  = 0;
        m_rr    = 0;
        cyc     = 0;
    endtask

    // One clock: advance the model across the edge, then drive the next inputs.
    task automatic step(input logic [NR-1:0] nreq, input logic novr);
        exp_t e;
        int   g;
        int   off;
        logic pat;
        @(posedge clk);
        #1;
        cyc++;
        e.done = '0;
        if (!m_busy) begin
            if (req != '0) begin
                g       = pick(req, m_rr);
                m_busy  = 1'b1;
                m_g     = g;
                m_start = cyc;
                m_end   = cyc + code_len(g);
                m_rr    = (g + 1) % NR;
                grant_q.push_back('{id: g, cyc: cyc});
            end
        end else if (cyc == m_end) begin
            m_busy = 1'b0;
            m_idle = cyc;
            e.done = NR'(1 << m_g);
        end
        if (m_busy) begin
            off = cyc - m_start;
            pat = (off < (m_g + 1) * UNIT) && ((off % UNIT) < ON_CLK);
        end else begin
            pat = (((cyc - m_idle) / HB_CLK) % 2) == 1;
        end
        req      = nreq;
        override = novr;
        e.led    = pat | novr;
        e.busy   = m_busy;
        e.gid    = 2'(m_g);
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input logic [NR-1:0] r, input logic o);
        for (int i = 0; i < n; i++) begin
            step(r, o);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        exp_q.delete();
        grant_q.delete();
        #1;
        chk("rst_led", int'(led), int'(override));
        chk("rst_busy", int'(busy), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_done", int'(done), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: pops one prediction per clock and one grant event per busy rise.
    initial begin : monitor
        exp_t e;
        gnt_t gx;
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
            end else if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("led", int'(led), int'(e.led));
                chk("busy", int'(busy), int'(e.busy));
                chk("done", int'(done), int'(e.done));
                chk("grant_id", int'(grant_id), int'(e.gid));
                if (busy && !prev_busy) begin
                    if (grant_q.size() == 0) begin
                        chk("unexpected_grant", int'(busy), 0);
                    end else begin
                        gx = grant_q.pop_front();
                        chk("grant_evt_id", int'(grant_id), gx.id);
                        chk("grant_evt_cycle", cyc, gx.cyc);
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin : driver
        logic [NR-1:0] r;
        int            len;
        logic          o;
        model_reset();
        #3;
        apply_reset();

        // Heartbeat with nothing requested.
        run(64, 4'b0000, 1'b0);

        // Single code for requester 2.
        step(4'b0100, 1'b0);
        run(80, 4'b0000, 1'b0);

        // Reset in the middle of a PULSE_ON phase.
        step(4'b0100, 1'b0);
        run(3, 4'b0000, 1'b0);
        chk("pre_reset_led_on", int'(led), 1);
        #2;
        apply_reset();

        // Round-robin between requesters 0 and 3, held high.
        run(215, 4'b1001, 1'b0);
        run(100, 4'b0000, 1'b0);

        // Request dropped during the first pulse.
        run(3, 4'b0010, 1'b0);
        run(60, 4'b0000, 1'b0);

        // Override during GAP and during IDLE.
        step(4'b0100, 1'b0);
        run(50, 4'b0000, 1'b0);
        run(6, 4'b0000, 1'b1);
        run(10, 4'b0000, 1'b0);
        run(12, 4'b0000, 1'b1);
        run(10, 4'b0000, 1'b0);

        // Randomized request patterns and override.
        for (int s = 0; s < 40; s++) begin
            r = NR'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) begin
                r = '0;
            end
            len = $urandom_range(1, 60);
            o   = ($urandom_range(0, 7) == 0);
            run(len, r, o);
        end

        run(150, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        chk("grant_events_drained", grant_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
